vixen_trace_buffer: RTL and testbench

//  Synthesisable retired-instruction trace capture for the vixen core; supersedes the sim-only $display monitor.

---
 rtl/vixen_trace_pkg.sv | 40 ++++
 rtl/vixen_trace_if.sv | 45 ++++
 rtl/vixen_trace_ram.sv | 25 ++
 rtl/vixen_trace_buffer.sv | 156 +++++++++++++++
 tb/tb_vixen_trace_buffer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vixen_trace_pkg.sv
// Shared types and constants for the vixen retired-instruction trace buffer.
package vixen_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_STOPPED = 2'd3
  } trace_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_HALT      = 3'd1,
    CAUSE_TRAP      = 3'd2,
    CAUSE_TRIG      = 3'd3,
    CAUSE_TIMEOUT   = 3'd4,
    CAUSE_ARM_ABORT = 3'd5
  } trace_cause_t;

  localparam logic [1:0] MODE_WRAP = 2'd0;
  localparam logic [1:0] MODE_STOP = 2'd1;
  localparam logic [1:0] MODE_TRIG = 2'd2;

  localparam int TRACE_PC_W = 16;
  localparam int TRACE_OP_W = 16;

  // Record layout for the default core widths; matches the flat rd_data packing.
  typedef struct packed {
    logic [TRACE_PC_W-1:0] pc;
    logic [TRACE_OP_W-1:0] op;
    logic [3:0]            flags;
    logic                  halt;
    logic                  trap;
  } trace_rec_t;

  function automatic int rec_w(input int pc_w, input int op_w);
    return pc_w + op_w + 6;
  endfunction

endpackage

// File: rtl/vixen_trace_if.sv
// Probe, control and readback bus between the vixen core/host and the trace buffer.
interface vixen_trace_if
  import vixen_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 16,
  parameter int OP_W  = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = rec_w(PC_W, OP_W);

  logic            retire;
  logic [PC_W-1:0] ret_pc;
  logic [OP_W-1:0] ret_op;
  logic [3:0]      ret_flags;
  logic            ret_halt;
  logic            ret_trap;
  logic            arm;
  logic [1:0]      mode;
  logic [PC_W-1:0] trig_pc;
  logic            rd_en;
  logic [AW-1:0]   rd_idx;
  logic            rd_valid;
  logic [RW-1:0]   rd_data;
  logic            rd_err;
  logic [CW-1:0]   count;
  logic [1:0]      state;
  logic [2:0]      cause;
  logic [31:0]     cycles;
  logic [31:0]     retired;

  modport master (
    output retire, ret_pc, ret_op, ret_flags, ret_halt, ret_trap,
    output arm, mode, trig_pc, rd_en, rd_idx,
    input  rd_valid, rd_data, rd_err, count, state, cause, cycles, retired
  );

  modport slave (
    input  retire, ret_pc, ret_op, ret_flags, ret_halt, ret_trap,
    input  arm, mode, trig_pc, rd_en, rd_idx,
    output rd_valid, rd_data, rd_err, count, state, cause, cycles, retired
  );

endinterface

// File: rtl/vixen_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module vixen_trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 38
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_data_q;

  // Read samples the array before the same-edge write lands, giving old data on a collision.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vixen_trace_buffer.sv
// Retired-instruction trace capture: circular record store with halt/trap/PC-trigger/watchdog stop.
module vixen_trace_buffer
  import vixen_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PC_W    = 16,
  parameter int OP_W    = 16,
  parameter int POST    = 4,
  parameter int TIMEOUT = 1024
) (
  input logic          clk,
  input logic          rst_n,
  vixen_trace_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = rec_w(PC_W, OP_W);
  localparam int PW = (POST > 0) ? $clog2(POST + 1) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  trace_state_t state_q, state_d;
  trace_cause_t cause_q, cause_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] post_q, post_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [31:0]   retired_q, retired_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_err_q, rd_err_d;

  logic          capturing;
  logic          accept;
  logic          stop_mode;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] wr_data;
  logic [RW-1:0] ram_rd_data;

  assign capturing = (state_q == ST_CAPTURE) || (state_q == ST_POST);
  assign accept    = capturing && bus.retire && !bus.arm;
  assign stop_mode = bus.mode >= MODE_STOP;
  assign oldest    = (count_q == CW'(DEPTH)) ? wr_ptr_q : '0;
  assign rd_addr   = oldest + bus.rd_idx;
  assign wr_data   = {bus.ret_pc, bus.ret_op, bus.ret_flags, bus.ret_halt, bus.ret_trap};

  vixen_trace_ram #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_ram (
    .clk     (clk),
    .we      (accept),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .re      (bus.rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  // Arm always restarts and leaves cause NONE, even when a stop condition coincides with it.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    wdog_d     = wdog_q;
    cycles_d   = cycles_q;
    retired_d  = retired_q;
    rd_valid_d = bus.rd_en;
    rd_err_d   = bus.rd_en && (CW'(bus.rd_idx) >= count_q);

    if (bus.arm) begin
      state_d   = ST_CAPTURE;
      cause_d   = CAUSE_NONE;
      wr_ptr_d  = '0;
      count_d   = '0;
      post_d    = '0;
      wdog_d    = '0;
      cycles_d  = '0;
      retired_d = '0;
    end else if (capturing) begin
      if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
      if (bus.retire) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        wdog_d   = '0;
        if (count_q != CW'(DEPTH)) count_d = count_q + 1'b1;
        if (retired_q != 32'hFFFF_FFFF) retired_d = retired_q + 32'd1;
        if (stop_mode && bus.ret_trap) begin
          state_d = ST_STOPPED;
          cause_d = CAUSE_TRAP;
        end else if (stop_mode && bus.ret_halt) begin
          state_d = ST_STOPPED;
          cause_d = CAUSE_HALT;
        end else if (state_q == ST_POST) begin
          post_d = post_q - 1'b1;
          if (post_q == PW'(1)) begin
            state_d = ST_STOPPED;
            cause_d = CAUSE_TRIG;
          end
        end else if (bus.mode == MODE_TRIG && bus.ret_pc == bus.trig_pc) begin
          if (POST == 0) begin
            state_d = ST_STOPPED;
            cause_d = CAUSE_TRIG;
          end else begin
            state_d = ST_POST;
            post_d  = PW'(POST);
          end
        end
      end else if (TIMEOUT != 0) begin
        wdog_d = wdog_q + 1'b1;
        if (wdog_d == WW'(TIMEOUT)) begin
          state_d = ST_STOPPED;
          cause_d = CAUSE_TIMEOUT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cause_q    <= CAUSE_NONE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      wdog_q     <= '0;
      cycles_q   <= '0;
      retired_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      wdog_q     <= wdog_d;
      cycles_q   <= cycles_d;
      retired_q  <= retired_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // RAM has no reset, so data is masked to zero unless a valid in-range read completed.
  assign bus.rd_data  = (rd_valid_q && !rd_err_q) ? ram_rd_data : '0;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.count    = count_q;
  assign bus.state    = state_q;
  assign bus.cause    = cause_q;
  assign bus.cycles   = cycles_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_vixen_trace_buffer.sv
// Directed self-checking bench for vixen_trace_buffer (DEPTH=16, POST=4, TIMEOUT=8).
module tb_vixen_trace_buffer;
  import vixen_trace_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vixen_trace_if #(.DEPTH(16), .PC_W(16), .OP_W(16)) bus ();

  vixen_trace_buffer #(
    .DEPTH   (16),
    .PC_W    (16),
    .OP_W    (16),
    .POST    (4),
    .TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] exp_rec(input logic [15:0] pc, input logic h, input logic t);
    logic [15:0] p;
    p = pc;
    return {p, p ^ 16'hA5A5, p[4:1], h, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [15:0] tpc);
    bus.mode    = m;
    bus.trig_pc = tpc;
    bus.arm     = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask

  task automatic drive_retire(input logic [15:0] pc, input logic h, input logic t);
    logic [37:0] r;
    r = exp_rec(pc, h, t);
    bus.retire    = 1'b1;
    bus.ret_pc    = r[37:22];
    bus.ret_op    = r[21:6];
    bus.ret_flags = r[5:2];
    bus.ret_halt  = h;
    bus.ret_trap  = t;
  endtask

  task automatic do_retire(input logic [15:0] pc, input logic h, input logic t);
    drive_retire(pc, h, t);
    step();
    bus.retire   = 1'b0;
    bus.ret_halt = 1'b0;
    bus.ret_trap = 1'b0;
  endtask

  task automatic read_entry(input logic [3:0] idx, output logic [37:0] data,
                            output logic err, output logic valid);
    bus.rd_en  = 1'b1;
    bus.rd_idx = idx;
    step();
    bus.rd_en = 1'b0;
    data  = bus.rd_data;
    err   = bus.rd_err;
    valid = bus.rd_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.state !== ST_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", bus.state, ST_IDLE); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.cause !== CAUSE_NONE) begin errors++; $display("[TB] FAIL reset_cause: got %0d expected 0", bus.cause); end
    checks++; if ({bus.cycles, bus.retired} !== 64'd0) begin errors++; $display("[TB] FAIL reset_stats: got cycles=%0d retired=%0d expected 0/0", bus.cycles, bus.retired); end
    checks++; if ({bus.rd_valid, bus.rd_err, bus.rd_data} !== 40'd0) begin errors++; $display("[TB] FAIL reset_read: got valid=%b err=%b data=%h expected all zero", bus.rd_valid, bus.rd_err, bus.rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_retire(16'h0040, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd0 || bus.retired !== 32'd0) begin errors++; $display("[TB] FAIL idle_ignores_retire: got count=%0d retired=%0d expected 0/0", bus.count, bus.retired); end
  endtask

  task automatic test_capture_basic();
    logic [37:0] d; logic e, v;
    do_arm(MODE_WRAP, 16'h0);
    for (int i = 0; i < 5; i++) do_retire(16'(2 * i), 1'b0, 1'b0);
    checks++; if (bus.state !== ST_CAPTURE) begin errors++; $display("[TB] FAIL basic_state: got %0d expected %0d", bus.state, ST_CAPTURE); end
    checks++; if (bus.count !== 5'd5) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 5", bus.count); end
    checks++; if (bus.retired !== 32'd5) begin errors++; $display("[TB] FAIL basic_retired: got %0d expected 5", bus.retired); end
    read_entry(4'd0, d, e, v);
    checks++; if ({v, e, d} !== {1'b1, 1'b0, exp_rec(16'h0000, 1'b0, 1'b0)}) begin errors++; $display("[TB] FAIL basic_rd0: got v=%b e=%b d=%h expected 1/0/%h", v, e, d, exp_rec(16'h0000, 1'b0, 1'b0)); end
    read_entry(4'd4, d, e, v);
    checks++; if ({v, e, d} !== {1'b1, 1'b0, exp_rec(16'h0008, 1'b0, 1'b0)}) begin errors++; $display("[TB] FAIL basic_rd4: got v=%b e=%b d=%h expected 1/0/%h", v, e, d, exp_rec(16'h0008, 1'b0, 1'b0)); end
  endtask

  task automatic test_wrap_back_to_back();
    logic [37:0] d; logic e, v;
    do_arm(MODE_WRAP, 16'h0);
    for (int i = 0; i < 20; i++) do_retire(16'(2 * i), 1'b0, 1'b0);
    checks++; if (bus.state !== ST_CAPTURE || bus.count !== 5'd16) begin errors++; $display("[TB] FAIL wrap_state_count: got state=%0d count=%0d expected 1/16", bus.state, bus.count); end
    checks++; if (bus.retired !== 32'd20) begin errors++; $display("[TB] FAIL wrap_retired: got %0d expected 20", bus.retired); end
    bus.rd_en  = 1'b1;
    bus.rd_idx = 4'd0;
    step();
    bus.rd_idx = 4'd15;
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rec(16'h0008, 1'b0, 1'b0)) begin errors++; $display("[TB] FAIL wrap_rd0: got v=%b d=%h expected 1/%h", bus.rd_valid, bus.rd_data, exp_rec(16'h0008, 1'b0, 1'b0)); end
    step();
    bus.rd_idx = 4'd0;
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rec(16'h0026, 1'b0, 1'b0)) begin errors++; $display("[TB] FAIL wrap_rd15: got v=%b d=%h expected 1/%h", bus.rd_valid, bus.rd_data, exp_rec(16'h0026, 1'b0, 1'b0)); end
    drive_retire(16'h0028, 1'b0, 1'b0);
    step();
    bus.retire = 1'b0;
    bus.rd_en  = 1'b0;
    checks++; if (bus.rd_data !== exp_rec(16'h0008, 1'b0, 1'b0)) begin errors++; $display("[TB] FAIL read_before_write: got %h expected %h", bus.rd_data, exp_rec(16'h0008, 1'b0, 1'b0)); end
    read_entry(4'd0, d, e, v);
    checks++; if (d !== exp_rec(16'h000A, 1'b0, 1'b0)) begin errors++; $display("[TB] FAIL wrap_new_oldest: got %h expected %h", d, exp_rec(16'h000A, 1'b0, 1'b0)); end
    read_entry(4'd15, d, e, v);
    checks++; if (d !== exp_rec(16'h0028, 1'b0, 1'b0)) begin errors++; $display("[TB] FAIL wrap_new_newest: got %h expected %h", d, exp_rec(16'h0028, 1'b0, 1'b0)); end
  endtask

  task automatic test_halt_trap();
    logic [37:0] d; logic e, v;
    do_arm(MODE_WRAP, 16'h0);
    do_retire(16'h0200, 1'b1, 1'b0);
    checks++; if (bus.state !== ST_CAPTURE) begin errors++; $display("[TB] FAIL mode0_halt_nostop: got state=%0d expected %0d", bus.state, ST_CAPTURE); end
    do_arm(MODE_STOP, 16'h0);
    do_retire(16'h0300, 1'b1, 1'b0);
    checks++; if (bus.state !== ST_STOPPED || bus.cause !== CAUSE_HALT || bus.count !== 5'd1) begin errors++; $display("[TB] FAIL halt_stop: got state=%0d cause=%0d count=%0d expected 3/1/1", bus.state, bus.cause, bus.count); end
    do_arm(MODE_STOP, 16'h0);
    do_retire(16'h0100, 1'b0, 1'b0);
    do_retire(16'h0102, 1'b0, 1'b0);
    do_retire(16'h0104, 1'b1, 1'b1);
    checks++; if (bus.state !== ST_STOPPED || bus.cause !== CAUSE_TRAP || bus.count !== 5'd3) begin errors++; $display("[TB] FAIL trap_stop: got state=%0d cause=%0d count=%0d expected 3/2/3", bus.state, bus.cause, bus.count); end
    do_retire(16'h0106, 1'b0, 1'b0);
    do_retire(16'h0108, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd3 || bus.retired !== 32'd3 || bus.state !== ST_STOPPED) begin errors++; $display("[TB] FAIL trap_frozen: got count=%0d retired=%0d state=%0d expected 3/3/3", bus.count, bus.retired, bus.state); end
    read_entry(4'd2, d, e, v);
    checks++; if (d !== exp_rec(16'h0104, 1'b1, 1'b1)) begin errors++; $display("[TB] FAIL trap_record: got %h expected %h", d, exp_rec(16'h0104, 1'b1, 1'b1)); end
  endtask

  task automatic test_trigger();
    logic [37:0] d; logic e, v;
    do_arm(MODE_TRIG, 16'h0010);
    for (int i = 0; i <= 16; i++) begin
      do_retire(16'(2 * i), 1'b0, 1'b0);
      if (i == 8) begin
        checks++; if (bus.state !== ST_POST) begin errors++; $display("[TB] FAIL trig_post_state: got %0d expected %0d", bus.state, ST_POST); end
      end
    end
    checks++; if (bus.state !== ST_STOPPED || bus.cause !== CAUSE_TRIG) begin errors++; $display("[TB] FAIL trig_stop: got state=%0d cause=%0d expected 3/3", bus.state, bus.cause); end
    checks++; if (bus.count !== 5'd13 || bus.retired !== 32'd13) begin errors++; $display("[TB] FAIL trig_count: got count=%0d retired=%0d expected 13/13", bus.count, bus.retired); end
    read_entry(4'd12, d, e, v);
    checks++; if ({e, d} !== {1'b0, exp_rec(16'h0018, 1'b0, 1'b0)}) begin errors++; $display("[TB] FAIL trig_last: got e=%b d=%h expected 0/%h", e, d, exp_rec(16'h0018, 1'b0, 1'b0)); end
    read_entry(4'd13, d, e, v);
    checks++; if ({v, e, d} !== {1'b1, 1'b1, 38'd0}) begin errors++; $display("[TB] FAIL trig_past_end: got v=%b e=%b d=%h expected 1/1/0", v, e, d); end
  endtask

  task automatic test_timeout();
    do_arm(MODE_WRAP, 16'h0);
    do_retire(16'h0050, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step();
    checks++; if (bus.state !== ST_CAPTURE) begin errors++; $display("[TB] FAIL timeout_early: got state=%0d expected %0d", bus.state, ST_CAPTURE); end
    step();
    checks++; if (bus.state !== ST_STOPPED || bus.cause !== CAUSE_TIMEOUT) begin errors++; $display("[TB] FAIL timeout_stop: got state=%0d cause=%0d expected 3/4", bus.state, bus.cause); end
    checks++; if (bus.cycles !== 32'd9) begin errors++; $display("[TB] FAIL timeout_cycles: got %0d expected 9", bus.cycles); end
    step();
    step();
    checks++; if (bus.cycles !== 32'd9) begin errors++; $display("[TB] FAIL stopped_cycles_frozen: got %0d expected 9", bus.cycles); end
  endtask

  task automatic test_arm_abort();
    logic [37:0] d; logic e, v;
    do_arm(MODE_STOP, 16'h0);
    do_retire(16'h0060, 1'b0, 1'b0);
    do_retire(16'h0062, 1'b0, 1'b0);
    bus.arm = 1'b1;
    do_retire(16'h0064, 1'b1, 1'b1);
    bus.arm = 1'b0;
    checks++; if (bus.state !== ST_CAPTURE || bus.cause !== CAUSE_NONE) begin errors++; $display("[TB] FAIL abort_state: got state=%0d cause=%0d expected 1/0", bus.state, bus.cause); end
    checks++; if (bus.count !== 5'd0 || bus.retired !== 32'd0 || bus.cycles !== 32'd0) begin errors++; $display("[TB] FAIL abort_cleared: got count=%0d retired=%0d cycles=%0d expected 0/0/0", bus.count, bus.retired, bus.cycles); end
    do_retire(16'h0070, 1'b0, 1'b0);
    do_retire(16'h0072, 1'b0, 1'b0);
    read_entry(4'd3, d, e, v);
    checks++; if ({v, e, d} !== {1'b1, 1'b1, 38'd0}) begin errors++; $display("[TB] FAIL abort_rd_err: got v=%b e=%b d=%h expected 1/1/0", v, e, d); end
    read_entry(4'd1, d, e, v);
    checks++; if ({e, d} !== {1'b0, exp_rec(16'h0072, 1'b0, 1'b0)}) begin errors++; $display("[TB] FAIL abort_rd1: got e=%b d=%h expected 0/%h", e, d, exp_rec(16'h0072, 1'b0, 1'b0)); end
  endtask

  task automatic test_async_reset();
    logic [37:0] d; logic e, v;
    do_arm(MODE_WRAP, 16'h0);
    do_retire(16'h0080, 1'b0, 1'b0);
    do_retire(16'h0082, 1'b0, 1'b0);
    do_retire(16'h0084, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.state !== ST_IDLE || bus.count !== 5'd0 || bus.retired !== 32'd0 || bus.cycles !== 32'd0) begin errors++; $display("[TB] FAIL async_reset: got state=%0d count=%0d retired=%0d cycles=%0d expected all 0", bus.state, bus.count, bus.retired, bus.cycles); end
    @(negedge clk);
    rst_n = 1'b1;
    read_entry(4'd0, d, e, v);
    checks++; if ({v, e, d} !== {1'b1, 1'b1, 38'd0}) begin errors++; $display("[TB] FAIL async_reset_unreadable: got v=%b e=%b d=%h expected 1/1/0", v, e, d); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.retire    = 1'b0;
    bus.ret_pc    = '0;
    bus.ret_op    = '0;
    bus.ret_flags = '0;
    bus.ret_halt  = 1'b0;
    bus.ret_trap  = 1'b0;
    bus.arm       = 1'b0;
    bus.mode      = MODE_WRAP;
    bus.trig_pc   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_idx    = '0;
    $display("[TB] starting vixen_trace_buffer bench");
    test_reset();
    test_capture_basic();
    test_wrap_back_to_back();
    test_halt_trap();
    test_trigger();
    test_timeout();
    test_arm_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
